// File: rtl/fpu_pkg.sv
// Shared definitions for the queued binary32 coprocessor front end:
// opcodes, field widths and the operation-queue entry layout.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  op_sel;
    } op_entry_t;

    localparam int ENTRY_W = $bits(op_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head and full/empty flags.
// A write into a full FIFO is accepted when the head leaves on the same edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_rd;
    logic             do_wr;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rptr_q];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array: written at the tail, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= ptr_inc(wptr_q);
            if (do_rd) rptr_q <= ptr_inc(rptr_q);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fpu_wrapper.sv
// Queued binary32 add/sub/mul coprocessor: operation FIFO, one-cycle
// combinational datapath, result FIFO and a registered popped result.
module fpu_wrapper
    import fpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  op_sel,
    input  logic        op_strobe,
    input  logic        cpu_pop,
    output logic [31:0] result
);

    op_entry_t   push_e;
    op_entry_t   head_e;
    logic        op_full, op_empty, res_full, res_empty, exec;
    logic [31:0] alu_res, res_head;
    logic [31:0] result_q;

    assign push_e.op1    = op1;
    assign push_e.op2    = op2;
    assign push_e.op_sel = op_sel;
    assign exec          = !op_empty && !res_full;
    assign result        = result_q;

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_op_fifo (
        .clk(clk), .n_rst(n_rst),
        .wr_en_i(op_strobe), .wr_data_i(push_e),
        .rd_en_i(exec), .rd_data_o(head_e),
        .full_o(op_full), .empty_o(op_empty)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk(clk), .n_rst(n_rst),
        .wr_en_i(exec), .wr_data_i(alu_res),
        .rd_en_i(cpu_pop), .rd_data_o(res_head),
        .full_o(res_full), .empty_o(res_empty)
    );

    logic               sa, sb, sl, swap;
    logic [EXP_W-1:0]   ea, eb, el, es, diff;
    logic [23:0]        ma, mb, ml, ms;
    logic [26:0]        s_ext, s_sh;
    logic               s_stk;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic [26:0]        norm;
    logic [FRAC_W-1:0]  f_add, f_mul;
    logic signed [9:0]  e_add, e_mul;
    logic [47:0]        prod;
    logic               s_mul;
    logic [31:0]        add_res, mul_res;

    // Head operation: align/add/normalise, 24x24 multiply, opcode select.
    always_comb begin
        ea    = head_e.op1[30:23];
        eb    = head_e.op2[30:23];
        ma    = (ea != '0) ? {1'b1, head_e.op1[22:0]} : '0;
        mb    = (eb != '0) ? {1'b1, head_e.op2[22:0]} : '0;
        sa    = head_e.op1[31];
        sb    = head_e.op2[31] ^ (head_e.op_sel == OP_SUB);
        swap  = {eb, mb[22:0]} > {ea, ma[22:0]};
        sl    = swap ? sb : sa;
        el    = swap ? eb : ea;
        es    = swap ? ea : eb;
        ml    = swap ? mb : ma;
        ms    = swap ? ma : mb;
        diff  = el - es;
        s_ext = {ms, 3'b000};
        if (diff >= 8'd27) begin
            s_sh  = '0;
            s_stk = |ms;
        end else begin
            s_sh  = s_ext >> diff;
            s_stk = |(s_ext & ((27'd1 << diff) - 27'd1));
        end
        s_sh[0] = s_sh[0] | s_stk;
        if (sa == sb) sum = {1'b0, ml, 3'b000} + {1'b0, s_sh};
        else          sum = {1'b0, ml, 3'b000} - {1'b0, s_sh};
        lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        norm = sum[26:0] << lz;
        if (sum[27]) begin
            e_add = $signed({2'b00, el}) + 10'sd1;
            f_add = sum[26:4];
        end else begin
            e_add = $signed({2'b00, el}) - $signed({5'b00000, lz});
            f_add = norm[25:3];
        end
        if (sum == '0)             add_res = '0;
        else if (e_add >= 10'sd255) add_res = {sl, 8'hFF, 23'd0};
        else if (e_add <= 10'sd0)   add_res = {sl, 31'd0};
        else                        add_res = {sl, e_add[7:0], f_add};

        s_mul = head_e.op1[31] ^ head_e.op2[31];
        prod  = {24'd0, ma} * {24'd0, mb};
        e_mul = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
              + (prod[47] ? 10'sd1 : 10'sd0);
        f_mul = prod[47] ? prod[46:24] : prod[45:23];
        if (ea == '0 || eb == '0)   mul_res = {s_mul, 31'd0};
        else if (e_mul >= 10'sd255) mul_res = {s_mul, 8'hFF, 23'd0};
        else if (e_mul <= 10'sd0)   mul_res = {s_mul, 31'd0};
        else                        mul_res = {s_mul, e_mul[7:0], f_mul};

        case (head_e.op_sel)
            OP_ADD, OP_SUB: alu_res = add_res;
            OP_MUL:         alu_res = mul_res;
            default:        alu_res = '0;
        endcase
    end

    // Popped result register, held until the next successful pop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                     result_q <= '0;
        else if (cpu_pop && !res_empty) result_q <= res_head;
    end

endmodule

// File: tb/tb_fpu_wrapper.sv
// Bench for fpu_wrapper: fixed vectors, multi-cycle sequences and
// random traffic against a queue-level model using real arithmetic.
module tb_fpu_wrapper;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] op1, op2;
    logic [2:0]  op_sel;
    logic        op_strobe, cpu_pop;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    op_entry_t   m_ops[$];
    logic [31:0] m_res[$];
    logic [31:0] m_result;

    fpu_wrapper #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .n_rst(n_rst), .op1(op1), .op2(op2),
        .op_sel(op_sel), .op_strobe(op_strobe),
        .cpu_pop(cpu_pop), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  o;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic real f2d(input logic [31:0] f);
        logic [10:0] e11;
        if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
        e11 = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'd0});
    endfunction

    // Round-toward-zero double -> binary32 with flush/saturate to inf.
    function automatic logic [31:0] d2f(input real r);
        logic [63:0] x;
        int fe;
        x = $realtobits(r);
        if (x[62:0] == 63'd0) return {x[63], 31'd0};
        fe = int'(x[62:52]) - 896;
        if (fe <= 0) return {x[63], 31'd0};
        if (fe >= 255) return {x[63], 8'hFF, 23'd0};
        return {x[63], fe[7:0], x[51:29]};
    endfunction

    function automatic logic [31:0] fmodel(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0] o);
        real r;
        case (o)
            OP_ADD: begin
                r = f2d(a) + f2d(b);
                return (r == 0.0) ? 32'd0 : d2f(r);
            end
            OP_SUB: begin
                r = f2d(a) - f2d(b);
                return (r == 0.0) ? 32'd0 : d2f(r);
            end
            OP_MUL: return d2f(f2d(a) * f2d(b));
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_ops.delete();
        m_res.delete();
        m_result = 32'd0;
    endtask

    // One clock: drive at negedge, update model at posedge, end at negedge.
    task automatic step(input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] o,
                        input logic p);
        bit dp, dx, dw;
        op_entry_t e;
        op_strobe = s; op1 = a; op2 = b; op_sel = o; cpu_pop = p;
        @(posedge clk);
        dp = p && (m_res.size() > 0);
        dx = (m_ops.size() > 0) && (m_res.size() < 8);
        dw = s && ((m_ops.size() < 8) || dx);
        if (dp) m_result = m_res.pop_front();
        if (dx) begin
            e = m_ops.pop_front();
            m_res.push_back(fmodel(e.op1, e.op2, e.op_sel));
        end
        if (dw) begin
            e.op1 = a; e.op2 = b; e.op_sel = o;
            m_ops.push_back(e);
        end
        @(negedge clk);
        op_strobe = 1'b0;
        cpu_pop   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic pop();
        step(0, 0, 0, 0, 1);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] o);
        step(1, a, b, o, 0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        model_clear();
    endtask

    task automatic gen(output logic [31:0] a, output logic [31:0] b,
                       output logic [2:0] o);
        int k, ea, eb;
        k = $urandom_range(0, 9);
        o = (k < 4) ? OP_ADD : (k < 7) ? OP_SUB :
            (k < 9) ? OP_MUL : 3'($urandom);
        ea = $urandom_range(1, 254);
        if (o == OP_MUL) eb = $urandom_range(1, 254);
        else begin
            eb = ea + $urandom_range(0, 56) - 28;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
        end
        if ($urandom_range(0, 15) == 0) ea = 0;
        if ($urandom_range(0, 15) == 0) eb = 0;
        a = {1'($urandom), 8'(ea), 23'($urandom)};
        b = {1'($urandom), 8'(eb), 23'($urandom)};
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  o;
        logic        s, p;

        tbl[0]  = '{"add_2.5_3.5", 32'h40200000, 32'h40600000, OP_ADD, 32'h40C00000};
        tbl[1]  = '{"add_cancel",  32'hC61C4238, 32'h461C4238, OP_ADD, 32'h00000000};
        tbl[2]  = '{"sub_3.5_2.5", 32'h40600000, 32'h40200000, OP_SUB, 32'h3F800000};
        tbl[3]  = '{"mul_1_m6",    32'h3F800000, 32'hC0C00000, OP_MUL, 32'hC0C00000};
        tbl[4]  = '{"mul_m3_m4",   32'hC0400000, 32'hC0800000, OP_MUL, 32'h41400000};
        tbl[5]  = '{"sub_sticky",  32'h3F800000, 32'h33800001, OP_SUB, 32'h3F7FFFFE};
        tbl[6]  = '{"mul_ovf",     32'h7F000000, 32'h40000000, OP_MUL, 32'h7F800000};
        tbl[7]  = '{"mul_unf",     32'h80800000, 32'h3F000000, OP_MUL, 32'h80000000};
        tbl[8]  = '{"add_ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000};
        tbl[9]  = '{"add_denorm",  32'h00400000, 32'h3F800000, OP_ADD, 32'h3F800000};
        tbl[10] = '{"bad_opcode",  32'h40200000, 32'h40600000, 3'b111, 32'h00000000};
        tbl[11] = '{"mul_zero",    32'h80000000, 32'h40600000, OP_MUL, 32'h80000000};

        n_rst = 1'b0; op1 = '0; op2 = '0; op_sel = '0;
        op_strobe = 1'b0; cpu_pop = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        pop();
        check("empty_pop0", result, 32'd0);
        pop();
        check("empty_pop1", result, 32'd0);

        push(32'hC475C000, 32'h4A1FE982, OP_ADD);
        push(32'h4475C000, 32'hCA1FE982, OP_ADD);
        push(32'h3FA00000, 32'h3FC00000, OP_MUL);
        push(32'h4475C000, 32'h4A1FE982, OP_ADD);
        idle(20);
        pop(); check("seq0", result, 32'h4A1FDA26);
        pop(); check("seq1", result, 32'hCA1FDA26);
        pop(); check("seq2", result, 32'h3FF00000);
        pop(); check("seq3", result, 32'h4A1FF8DE);

        foreach (tbl[i]) begin
            push(tbl[i].a, tbl[i].b, tbl[i].o);
            idle(1);
            pop();
            check(tbl[i].name, result, tbl[i].exp);
        end

        push(32'h40600000, 32'h40200000, OP_ADD);
        pop();
        check("lat_early_pop", result, tbl[11].exp);
        pop();
        check("lat_n_plus_2", result, 32'h40C00000);

        do_reset();
        for (int k = 1; k <= 20; k++)
            push(d2f(real'(k)), 32'h3F800000, OP_MUL);
        idle(2);
        for (int j = 0; j < 20; j++) begin
            pop();
            check($sformatf("fill%0d", j), result,
                  d2f(real'((j < 16) ? j + 1 : 16)));
        end

        push(32'h40200000, 32'h40600000, OP_ADD);
        push(32'h3F800000, 32'hC0C00000, OP_MUL);
        push(32'h40600000, 32'h40200000, OP_SUB);
        idle(2);
        pop();
        check("pre_async", result, 32'h40C00000);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst", result, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        model_clear();
        pop(); check("post_rst_pop0", result, 32'd0);
        pop(); check("post_rst_pop1", result, 32'd0);

        for (int i = 0; i < 400; i++) begin
            gen(a, b, o);
            s = ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 2) != 0);
            step(s, a, b, o, p);
            check("rand", result, m_result);
        end
        for (int i = 0; i < 20; i++) begin
            pop();
            check("drain", result, m_result);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
